// File: rtl/nic_pkg.sv
// Shared NIC datapath defaults and the packet framing state used by the steering logic.
package nic_pkg;

    localparam int unsigned NIC_DW          = 512;
    localparam int unsigned STEER_FIELD_W   = 16;
    localparam logic [STEER_FIELD_W-1:0] NIC_MATCH_VALUE = 16'h88B5;

    typedef enum logic {
        FRAME_SOP = 1'b0,
        FRAME_MID = 1'b1
    } frame_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: head entry drives the output, skid entry absorbs one beat of backpressure.
module axis_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         head_vld_q, head_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    always_comb begin
        push       = in_valid & ready_q;
        pop        = head_vld_q & out_ready;
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        if (pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = push;
                if (push) begin
                    skid_d = in_data;
                end
            end else begin
                head_vld_d = push;
                if (push) begin
                    head_d = in_data;
                end
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_vld_d = 1'b1;
                head_d     = in_data;
            end else begin
                skid_vld_d = 1'b1;
                skid_d     = in_data;
            end
        end
        // The skid entry only fills behind a valid head, so a free skid slot means room.
        ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = head_q;
    assign out_valid = head_vld_q;

endmodule

// File: rtl/axis_pkt_steer.sv
// Classifies each AXI-Stream packet on a first-beat field, tags every beat with a port select, and counts delivered packets.
module axis_pkt_steer
    import nic_pkg::*;
#(
    parameter int unsigned                DW          = NIC_DW,
    parameter int unsigned                FIELD_LSB   = 96,
    parameter logic [STEER_FIELD_W-1:0]   MATCH_VALUE = NIC_MATCH_VALUE
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] axis_in_tdata,
    input  logic          axis_in_tlast,
    input  logic          axis_in_tvalid,
    output logic          axis_in_tready,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tlast,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready,
    output logic          port_select,
    output logic [31:0]   pkt_count0,
    output logic [31:0]   pkt_count1,
    input  logic          clear_counts
);

    localparam int unsigned PW = DW + 2;

    frame_state_e state_q, state_d;
    logic         sel_q, sel_d;
    logic         in_sel_c;
    logic         in_fire, out_fire;
    logic [31:0]  pkt_count0_q, pkt_count0_d;
    logic [31:0]  pkt_count1_q, pkt_count1_d;
    logic [PW-1:0] in_payload, out_payload;
    logic         buf_in_ready, buf_out_valid;

    assign in_fire  = axis_in_tvalid & buf_in_ready;
    assign out_fire = buf_out_valid & axis_out_tready;

    // Framing: the first beat decides, later beats reuse the latched decision.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        in_sel_c = (state_q == FRAME_SOP)
                 ? (axis_in_tdata[FIELD_LSB +: STEER_FIELD_W] == MATCH_VALUE)
                 : sel_q;
        if (in_fire) begin
            if (state_q == FRAME_SOP) begin
                sel_d = in_sel_c;
            end
            state_d = axis_in_tlast ? FRAME_SOP : FRAME_MID;
        end
    end

    // Clear wins over a coincident increment.
    always_comb begin
        pkt_count0_d = pkt_count0_q;
        pkt_count1_d = pkt_count1_q;
        if (clear_counts) begin
            pkt_count0_d = '0;
            pkt_count1_d = '0;
        end else if (out_fire && out_payload[1]) begin
            if (out_payload[0]) begin
                pkt_count1_d = pkt_count1_q + 32'd1;
            end else begin
                pkt_count0_d = pkt_count0_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= FRAME_SOP;
            sel_q        <= 1'b0;
            pkt_count0_q <= '0;
            pkt_count1_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pkt_count0_q <= pkt_count0_d;
            pkt_count1_q <= pkt_count1_d;
        end
    end

    assign in_payload = {axis_in_tdata, axis_in_tlast, in_sel_c};

    axis_skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_payload),
        .in_valid  (axis_in_tvalid),
        .in_ready  (buf_in_ready),
        .out_data  (out_payload),
        .out_valid (buf_out_valid),
        .out_ready (axis_out_tready)
    );

    assign axis_in_tready  = buf_in_ready;
    assign axis_out_tdata  = out_payload[PW-1:2];
    assign axis_out_tlast  = out_payload[1];
    assign port_select     = out_payload[0];
    assign axis_out_tvalid = buf_out_valid;
    assign pkt_count0      = pkt_count0_q;
    assign pkt_count1      = pkt_count1_q;

endmodule

// File: tb/tb_axis_pkt_steer.sv
// Randomized bench for axis_pkt_steer against a packet-level scoreboard model.
module tb_axis_pkt_steer;
    import nic_pkg::*;

    localparam int unsigned DW        = 512;
    localparam int unsigned FIELD_LSB = 96;
    localparam logic [15:0] MATCH     = 16'h88B5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          sel;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] axis_in_tdata;
    logic          axis_in_tlast;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [DW-1:0] axis_out_tdata;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic          port_select;
    logic [31:0]   pkt_count0;
    logic [31:0]   pkt_count1;
    logic          clear_counts;

    axis_pkt_steer #(.DW(DW), .FIELD_LSB(FIELD_LSB), .MATCH_VALUE(MATCH)) dut (
        .clk(clk), .resetn(resetn),
        .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .port_select(port_select), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
        .clear_counts(clear_counts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] s_data[$];
    bit            s_last[$];
    beat_t         pend_q[$];
    beat_t         exp_l[$];
    beat_t         got_l[$];
    bit            m_mid, m_sel;
    logic [31:0]   m_cnt0, m_cnt1;
    int            cyc, first_acc, last_acc, first_vld;
    int            spurious, stab_err, hold_err, max_occ, ready_low_cnt;
    bit            prev_stall, g_acc, clear_on_last;
    beat_t         prev_beat;
    logic          prev_sel;
    int            valid_pct, ready_pct, stall_start, stall_len;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] d;
        for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic int beat_diffs();
        int n = 0;
        foreach (exp_l[i]) if (i >= got_l.size() || got_l[i] !== exp_l[i]) n++;
        return n;
    endfunction

    task automatic queue_pkt(input int len, input logic [15:0] field);
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = rand_word();
            if (i == 0) d[FIELD_LSB +: 16] = field;
            s_data.push_back(d);
            s_last.push_back(i == len - 1);
        end
    endtask

    task automatic clear_stats();
        exp_l.delete(); got_l.delete();
        first_acc = -1; last_acc = -1; first_vld = -1; cyc = 0;
        spurious = 0; stab_err = 0; hold_err = 0; max_occ = 0; ready_low_cnt = 0;
        valid_pct = 100; ready_pct = 100; stall_start = 0; stall_len = 0; clear_on_last = 0;
    endtask

    task automatic reset_assert();
        resetn = 1'b0; axis_in_tvalid = 1'b0; axis_in_tlast = 1'b0;
        axis_in_tdata = '0; axis_out_tready = 1'b1; clear_counts = 1'b0;
        s_data.delete(); s_last.delete(); pend_q.delete();
        m_mid = 0; m_sel = 0; m_cnt0 = '0; m_cnt1 = '0;
        prev_stall = 0; prev_sel = 1'b0; prev_beat = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
    endtask

    task automatic reset_release();
        resetn = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    // One cycle: observe handshakes at mid-cycle, update the model, then advance.
    task automatic step();
        bit acc, fire;
        beat_t b, ob;
        acc = axis_in_tvalid && axis_in_tready;
        fire = axis_out_tvalid && axis_out_tready;
        ob = {axis_out_tdata, axis_out_tlast, port_select};
        if (prev_stall && (!axis_out_tvalid || ob !== prev_beat)) stab_err++;
        if (!axis_out_tvalid && port_select !== prev_sel) hold_err++;
        if (axis_out_tvalid && first_vld < 0) first_vld = cyc;
        if (!axis_in_tready) ready_low_cnt++;
        if (fire) begin
            got_l.push_back(ob);
            if (pend_q.size() == 0) spurious++;
            else begin
                b = pend_q.pop_front();
                exp_l.push_back(b);
            end
        end
        if (clear_counts) begin
            m_cnt0 = '0; m_cnt1 = '0;
        end else if (fire && exp_l.size() != 0 && exp_l[$].last) begin
            if (exp_l[$].sel) m_cnt1 = m_cnt1 + 32'd1;
            else m_cnt0 = m_cnt0 + 32'd1;
        end
        if (acc) begin
            b.data = axis_in_tdata;
            b.last = axis_in_tlast;
            b.sel  = m_mid ? m_sel : (axis_in_tdata[FIELD_LSB +: 16] == MATCH);
            m_sel = b.sel;
            m_mid = !axis_in_tlast;
            pend_q.push_back(b);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (pend_q.size() > max_occ) max_occ = pend_q.size();
        prev_stall = axis_out_tvalid && !axis_out_tready;
        prev_beat = ob;
        prev_sel = port_select;
        g_acc = acc;
        cyc++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic run(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (s_data.size() == 0 && pend_q.size() == 0) break;
            axis_in_tvalid = (s_data.size() != 0) && ($urandom_range(99) < valid_pct);
            axis_in_tdata  = (s_data.size() != 0) ? s_data[0] : '0;
            axis_in_tlast  = (s_data.size() != 0) ? s_last[0] : 1'b0;
            axis_out_tready = (c >= stall_start && c < stall_start + stall_len) ? 1'b0
                            : ($urandom_range(99) < ready_pct);
            clear_counts = clear_on_last && axis_out_tvalid && axis_out_tready && axis_out_tlast;
            step();
            if (g_acc) begin
                void'(s_data.pop_front());
                void'(s_last.pop_front());
            end
        end
        axis_in_tvalid = 1'b0;
        clear_counts = 1'b0;
    endtask

    task automatic test_reset();
        clear_stats();
        reset_assert();
        axis_in_tvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if (axis_in_tready !== 1'b0) $display("FAIL rst_tready got %b want 0", axis_in_tready); else n_pass++;
        n_checks++; if (axis_out_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", axis_out_tvalid); else n_pass++;
        n_checks++; if (axis_out_tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", axis_out_tlast); else n_pass++;
        n_checks++; if (axis_out_tdata !== '0) $display("FAIL rst_tdata got nonzero want 0"); else n_pass++;
        n_checks++; if (port_select !== 1'b0) $display("FAIL rst_port_select got %b want 0", port_select); else n_pass++;
        n_checks++; if (pkt_count0 !== 32'd0 || pkt_count1 !== 32'd0)
            $display("FAIL rst_counts got %0h/%0h want 0/0", pkt_count0, pkt_count1); else n_pass++;
        axis_in_tvalid = 1'b0;
        resetn = 1'b1;
        #1;
        n_checks++; if (axis_in_tready !== 1'b0) $display("FAIL rst_tready_pre_edge got %b want 0", axis_in_tready); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++; if (axis_in_tready !== 1'b1) $display("FAIL rst_tready_first_edge got %b want 1", axis_in_tready); else n_pass++;
    endtask

    task automatic test_single_packet();
        int ones = 0;
        clear_stats(); reset_assert(); reset_release();
        queue_pkt(4, 16'h88B5);
        run(40);
        foreach (got_l[i]) if (got_l[i].sel === 1'b1) ones++;
        n_checks++; if (got_l.size() !== 4) $display("FAIL single_beats got %0d want 4", got_l.size()); else n_pass++;
        n_checks++; if (beat_diffs() !== 0) $display("FAIL single_data got %0d bad beats want 0", beat_diffs()); else n_pass++;
        n_checks++; if (ones !== 4) $display("FAIL single_sel got %0d sel=1 beats want 4", ones); else n_pass++;
        n_checks++; if (first_vld - first_acc !== 1) $display("FAIL single_latency got %0d want 1", first_vld - first_acc); else n_pass++;
        n_checks++; if (last_acc - first_acc !== 3) $display("FAIL single_throughput got %0d want 3", last_acc - first_acc); else n_pass++;
        n_checks++; if (pkt_count1 !== 32'd1 || pkt_count0 !== 32'd0)
            $display("FAIL single_counts got %0d/%0d want 0/1", pkt_count0, pkt_count1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] sels = '0;
        clear_stats(); reset_assert(); reset_release();
        queue_pkt(1, 16'h0800);
        queue_pkt(3, 16'h88B5);
        run(40);
        foreach (got_l[i]) if (i < 4) sels[i] = got_l[i].sel;
        n_checks++; if (got_l.size() !== 4) $display("FAIL b2b_beats got %0d want 4", got_l.size()); else n_pass++;
        n_checks++; if (sels !== 4'b1110) $display("FAIL b2b_sel got %b want 1110 (beat0 in lsb)", sels); else n_pass++;
        n_checks++; if (beat_diffs() !== 0) $display("FAIL b2b_data got %0d bad beats want 0", beat_diffs()); else n_pass++;
        n_checks++; if (last_acc - first_acc !== 3) $display("FAIL b2b_throughput got %0d want 3", last_acc - first_acc); else n_pass++;
        n_checks++; if (pkt_count0 !== 32'd1 || pkt_count1 !== 32'd1)
            $display("FAIL b2b_counts got %0d/%0d want 1/1", pkt_count0, pkt_count1); else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_stats(); reset_assert(); reset_release();
        stall_start = 2; stall_len = 5;
        queue_pkt(6, 16'h88B5);
        run(60);
        n_checks++; if (max_occ !== 2) $display("FAIL bp_occupancy got %0d want 2", max_occ); else n_pass++;
        n_checks++; if (ready_low_cnt !== 5) $display("FAIL bp_tready_low got %0d cycles want 5", ready_low_cnt); else n_pass++;
        n_checks++; if (stab_err !== 0) $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err); else n_pass++;
        n_checks++; if (got_l.size() !== 6 || spurious !== 0)
            $display("FAIL bp_beats got %0d (+%0d extra) want 6", got_l.size(), spurious); else n_pass++;
        n_checks++; if (beat_diffs() !== 0) $display("FAIL bp_data got %0d bad beats want 0", beat_diffs()); else n_pass++;
        n_checks++; if (pkt_count1 !== 32'd1) $display("FAIL bp_count1 got %0d want 1", pkt_count1); else n_pass++;
    endtask

    task automatic test_wrap();
        clear_stats(); reset_assert(); reset_release();
        force dut.pkt_count0_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count0_q;
        m_cnt0 = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        n_checks++; if (pkt_count0 !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got %0h want ffffffff", pkt_count0); else n_pass++;
        queue_pkt(2, 16'h0800);
        run(40);
        n_checks++; if (pkt_count0 !== 32'd0) $display("FAIL wrap_count0 got %0h want 0", pkt_count0); else n_pass++;
        n_checks++; if (pkt_count1 !== 32'd0) $display("FAIL wrap_count1 got %0h want 0", pkt_count1); else n_pass++;
    endtask

    task automatic test_clear();
        clear_stats(); reset_assert(); reset_release();
        queue_pkt(1, 16'h0800);
        queue_pkt(1, 16'h88B5);
        run(40);
        n_checks++; if (pkt_count0 !== 32'd1 || pkt_count1 !== 32'd1)
            $display("FAIL clr_pre_counts got %0d/%0d want 1/1", pkt_count0, pkt_count1); else n_pass++;
        clear_on_last = 1;
        queue_pkt(3, 16'h88B5);
        run(40);
        clear_on_last = 0;
        n_checks++; if (pkt_count0 !== 32'd0 || pkt_count1 !== 32'd0)
            $display("FAIL clr_counts got %0d/%0d want 0/0", pkt_count0, pkt_count1); else n_pass++;
        n_checks++; if (pkt_count1 !== m_cnt1) $display("FAIL clr_model got %0d want %0d", pkt_count1, m_cnt1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ones = 0;
        clear_stats(); reset_assert(); reset_release();
        queue_pkt(4, 16'h0800);
        run(2);
        n_checks++; if (axis_out_tvalid !== 1'b1) $display("FAIL rmid_inflight got %b want 1", axis_out_tvalid); else n_pass++;
        reset_assert();
        n_checks++; if (axis_out_tvalid !== 1'b0 || axis_in_tready !== 1'b0 || port_select !== 1'b0)
            $display("FAIL rmid_outputs got v=%b r=%b sel=%b want 0/0/0", axis_out_tvalid, axis_in_tready, port_select); else n_pass++;
        reset_release();
        clear_stats();
        queue_pkt(2, 16'h88B5);
        run(40);
        foreach (got_l[i]) if (got_l[i].sel === 1'b1) ones++;
        n_checks++; if (got_l.size() !== 2 || ones !== 2)
            $display("FAIL rmid_steer got %0d beats %0d to port1 want 2/2", got_l.size(), ones); else n_pass++;
        n_checks++; if (pkt_count1 !== 32'd1 || pkt_count0 !== 32'd0)
            $display("FAIL rmid_counts got %0d/%0d want 0/1", pkt_count0, pkt_count1); else n_pass++;
    endtask

    task automatic test_random();
        int total = 0;
        int len;
        clear_stats(); reset_assert(); reset_release();
        valid_pct = 70; ready_pct = 60;
        for (int p = 0; p < 30; p++) begin
            len = int'($urandom_range(6, 1));
            total += len;
            queue_pkt(len, ($urandom_range(1) == 1) ? MATCH : 16'($urandom_range(16'hFFFF)));
        end
        run(4000);
        n_checks++; if (s_data.size() !== 0 || pend_q.size() !== 0)
            $display("FAIL rnd_drain got %0d/%0d left want 0/0", s_data.size(), pend_q.size()); else n_pass++;
        n_checks++; if (got_l.size() !== total || spurious !== 0)
            $display("FAIL rnd_beats got %0d (+%0d extra) want %0d", got_l.size(), spurious, total); else n_pass++;
        n_checks++; if (beat_diffs() !== 0) $display("FAIL rnd_data got %0d bad beats want 0", beat_diffs()); else n_pass++;
        n_checks++; if (stab_err !== 0 || hold_err !== 0)
            $display("FAIL rnd_stability got %0d/%0d want 0/0", stab_err, hold_err); else n_pass++;
        n_checks++; if (pkt_count0 !== m_cnt0 || pkt_count1 !== m_cnt1)
            $display("FAIL rnd_counts got %0d/%0d want %0d/%0d", pkt_count0, pkt_count1, m_cnt0, m_cnt1); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        axis_in_tvalid = 1'b0; axis_in_tlast = 1'b0; axis_in_tdata = '0;
        axis_out_tready = 1'b1; clear_counts = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_pkt_steer.md
AXIS_PKT_STEER -- requirements
Module: axis_pkt_steer

Interface
REQ-001 Parameter DW, default 512, SHALL set the TDATA width in bits.
REQ-002 Parameter FIELD_LSB, default 96, SHALL set the bit offset of the 16-bit steering field within the first beat of each packet.
REQ-003 Parameter MATCH_VALUE, default 16'h88B5, SHALL set the field value that steers a packet to port 1.
REQ-004 clk  input  1  sole clock; all logic is rising-edge.
REQ-005 resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 axis_in_tdata / axis_in_tlast / axis_in_tvalid  input  DW/1/1  upstream packet stream.
REQ-007 axis_in_tready  output  1  upstream backpressure, driven from a register.
REQ-008 axis_out_tdata / axis_out_tlast / axis_out_tvalid  output  DW/1/1  registered stream to the downstream two-way switch.
REQ-009 axis_out_tready  input  1  downstream backpressure.
REQ-010 port_select  output  1  steering decision for the beat currently on axis_out.
REQ-011 pkt_count0 / pkt_count1  output  32/32  packets delivered to port 0 / port 1.
REQ-012 clear_counts  input  1  synchronous clear of both packet counters.

Function
REQ-013 Input and output handshakes SHALL complete only when the respective tvalid and tready are both high in the same cycle.
REQ-014 The block SHALL buffer beats in a 2-entry skid buffer, each entry holding {tdata, tlast, sel}.
REQ-015 axis_in_tready SHALL be high whenever at least one buffer entry is free at the start of the cycle.
REQ-016 Latency SHALL be exactly 1 cycle from input acceptance to axis_out_tvalid when the buffer is empty.
REQ-017 Sustained throughput SHALL be one beat per cycle while axis_out_tready is held high.
REQ-018 A 1-bit state SHALL track framing: SOP, the next accepted beat starts a packet; MID, inside a packet.
REQ-019 On acceptance in SOP, sel SHALL be 1 iff tdata[FIELD_LSB+15:FIELD_LSB] == MATCH_VALUE, and the state SHALL go to MID unless tlast is high.
REQ-020 On acceptance in MID, sel SHALL equal the value latched at SOP, and tlast high SHALL return the state to SOP.
REQ-021 A single-beat packet (tlast on the first beat) SHALL be steered from its own field and SHALL leave the state in SOP.
REQ-022 port_select SHALL equal the sel of the head entry, and SHALL be constant for every beat of a packet while axis_out_tvalid is high.
REQ-023 When axis_out_tvalid is low, port_select SHALL hold its last value and SHALL NOT toggle.
REQ-024 axis_out_tdata, axis_out_tlast and port_select SHALL remain stable while axis_out_tvalid is high and axis_out_tready is low.
REQ-025 pkt_countN SHALL increment by 1 when a beat with tlast=1 and sel=N completes on axis_out, wrapping from 32'hFFFFFFFF to 0.
REQ-026 If clear_counts and an increment occur in the same cycle, both counters SHALL become 0.
REQ-027 Simultaneous input acceptance and output completion SHALL leave the buffer occupancy unchanged.

Reset
REQ-028 While resetn is low: axis_in_tready=0, axis_out_tvalid=0, axis_out_tlast=0, axis_out_tdata=0, port_select=0, both counters=0, buffer empty, state=SOP.
REQ-029 axis_in_tready SHALL rise on the first clock edge after resetn deasserts.
REQ-030 Reset asserted mid-packet SHALL discard all buffered beats, and the next accepted beat SHALL be treated as a start-of-packet.

Structure
REQ-031 The defaults for DW and the 16-bit MATCH_VALUE SHALL reside in a shared package, nic_pkg.
REQ-032 The 2-entry buffer SHALL be a sub-module, axis_skid_buffer, parameterised on payload width (DW+2).
REQ-033 The steering state machine and counters SHALL reside in axis_pkt_steer.

Verification
REQ-034 After reset, send a 4-beat packet with field=16'h88B5 and tready=1 -> 4 output beats with port_select=1 from cycle 1 on, pkt_count1=1.
REQ-035 Send a 1-beat packet with field=16'h0800 followed immediately by a 3-beat packet with field=16'h88B5 -> port_select 0 then 1,1,1, pkt_count0=1, pkt_count1=1.
REQ-036 Hold axis_out_tready low for 5 cycles mid-packet -> axis_in_tready falls after 2 beats are buffered, outputs stay stable, no beat is lost or duplicated.
REQ-037 Preload pkt_count0=32'hFFFFFFFF via 2^32-1 packets (or a forced value), then send one port-0 packet -> pkt_count0=0.
REQ-038 Assert resetn low during beat 2 of a 4-beat packet, then send a new packet with field=16'h88B5 -> outputs clear, and the new packet is steered to port 1.
REQ-039 Assert clear_counts in the same cycle as a tlast beat completes -> both counters read 0.
